serdes_tx_scheduler: RTL

Round-robin scheduler that shares one 8-bit serializer lane among four byte requesters. Each granted byte goes out as a two-word frame: a header word carrying a sync nibble and the source id, then the payload word. The block drives the serializer's parallel-load side (ser_load/ser_data) and paces loads by the serializer's word time. It sits between the requester FIFOs and the serializer.

---
 rtl/serdes_tx_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/serdes_tx_scheduler.sv
// serdes_tx_scheduler: round-robin share of one serializer lane among four
// byte requesters; each grant is sent as a header word then a payload word.
module serdes_tx_scheduler #(
  parameter int         WORD_CYCLES = 8,
  parameter int         GAP_CYCLES  = 2,
  parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        ser_load,
  output logic [7:0]  ser_data,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    GAP
  } state_t;

  localparam logic [15:0] W_M1 = 16'(WORD_CYCLES - 1);
  localparam logic [15:0] G_M1 =
    16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [1:0]  ptr;
  logic [7:0]  payload;
  logic [7:0]  dbl;
  logic [3:0]  rot;
  logic [1:0]  ofs;
  logic [1:0]  win;
  logic        accept;
  logic        load_nxt;
  logic [7:0]  data_nxt;
  logic        done_nxt;

  // Rotate valids so bit 0 is the requester just after the last winner.
  always_comb begin
    dbl = {req_valid, req_valid};
    rot = 4'(dbl >> ({1'b0, ptr} + 3'd1));
    ofs = 2'd0;
    priority case (1'b1)
      rot[0]:  ofs = 2'd0;
      rot[1]:  ofs = 2'd1;
      rot[2]:  ofs = 2'd2;
      rot[3]:  ofs = 2'd3;
      default: ofs = 2'd0;
    endcase
    win = ptr + 2'd1 + ofs;
  end

  assign accept = enable && (state == IDLE)
                  && (req_valid != 4'b0000);

  // Ready strobe; held low while reset is asserted.
  always_comb begin
    req_ready = 4'b0000;
    if (accept && rst)
      req_ready = 4'b0001 << win;
  end

  assign busy = (state != IDLE);

  // State and word counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: word pacing in HDR/PAY, idle spacing in GAP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = HDR;
          cnt_nxt   = W_M1;
        end
      end
      HDR: begin
        if (cnt == '0) begin
          state_nxt = PAY;
          cnt_nxt   = W_M1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      PAY: begin
        if (cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
            cnt_nxt   = G_M1;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      GAP: begin
        if (cnt == '0)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt - 16'd1;
      end
    endcase
  end

  // Outputs to be registered: word loads and the completion pulse.
  always_comb begin
    load_nxt = 1'b0;
    data_nxt = payload;
    done_nxt = 1'b0;
    if (state == IDLE && accept) begin
      load_nxt = 1'b1;
      data_nxt = {SYNC_NIBBLE, 2'b00, win};
    end
    if (state == HDR && cnt == '0) begin
      load_nxt = 1'b1;
      data_nxt = payload;
    end
    if ((state == PAY || state == GAP)
        && state_nxt == IDLE)
      done_nxt = 1'b1;
  end

  // Grant bookkeeping: pointer, id and payload captured at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= 2'd3;
      grant_id <= 2'd0;
      payload  <= 8'h00;
    end else if (accept) begin
      ptr      <= win;
      grant_id <= win;
      payload  <= req_data[{win, 3'b000} +: 8];
    end
  end

  // Serializer load port and frame statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_load    <= 1'b0;
      ser_data    <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      ser_load   <= load_nxt;
      frame_done <= done_nxt;
      if (load_nxt)
        ser_data <= data_nxt;
      if (done_nxt)
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule
